// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// The state encodings are kept as plain constants so other blocks can decode the state without the enum type.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder: the only arithmetic cell in the serial datapath.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one full-adder cell and a registered carry.
// Results are held in output registers until the next operation completes.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per clock, WIDTH clocks
// DONE  | one-cycle done pulse, start accepted back-to-back
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           st, st_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             fa_s, fa_cout;
    logic             accept, last;

    full_adder_cell u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign accept  = start && (st == IDLE || st == DONE);
    assign last    = (st == RUN) && (cnt == CNT_LAST);
    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sum_nxt = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        busy   = 1'b0;
        done   = 1'b0;
        case (st)
            IDLE: begin
                if (accept) st_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) st_nxt = DONE;
            end
            DONE: begin
                done   = 1'b1;
                st_nxt = accept ? RUN : IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry.
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            c    <= sub;
            cnt  <= '0;
        end else if (st == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            c      <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum       <= sum_nxt;
                carry_out <= fa_cout;
                overflow  <= c ^ fa_cout;
            end
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, parametrised successor to the team's one-bit adder.
- Adds or subtracts two WIDTH-bit operands, one bit per clock, LSB first, using a single full-adder cell and a registered carry.
- Start/busy/done handshake. Results held in output registers until the next operation completes.
- Sits beside the combinational adder set as the area-minimal arithmetic option for slow control paths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  WIDTH  result, registered.
- carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Shift registers, counter and carry register cleared.
  - Takes effect immediately, including mid-RUN. The partial result is discarded and the output registers return to 0.
- FSM states are IDLE, RUN and DONE.
  - IDLE, start=1: load a_sh=a, b_sh = sub ? ~b : b, c=sub, cnt=0, latch sub. Next state RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, each edge:
    - s = a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0], b_sh[0], c).
    - a_sh and b_sh shift right; s shifts into the MSB of the internal sum_sh; cnt++.
    - When cnt = WIDTH-1 the bit being processed is the MSB: record c_in_msb = c, then go to DONE.
  - On the edge entering DONE:
    - sum <= final sum_sh (including the MSB bit).
    - carry_out <= carry out of the MSB.
    - overflow <= c_in_msb XOR that carry.
  - DONE lasts exactly one cycle with done=1.
    - start=1 in DONE is accepted as in IDLE (back-to-back); next state RUN.
    - Otherwise next state IDLE.
- Latency: start sampled at edge t means RUN during edges t+1..t+WIDTH and done=1 in the cycle following edge t+WIDTH.
  - Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start=1 while busy=1 is ignored; there is no queueing.
- a, b and sub are don't-care except in the cycle start is accepted.
- sum, carry_out and overflow change only on the edge entering DONE. They hold stable through the next RUN.
- WIDTH=1: result is sum=a^b, carry_out=a&b (add), which reproduces the one-bit half-adder truth table.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package serial_adder_pkg holds the state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One natural sub-module: full_adder_cell, combinational, with inputs x, y, cin and outputs s, cout. It is instantiated once for the per-bit datapath.
- The FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, sub=0, a=0x3C, b=0x45, start pulse -> busy high 8 cycles; done 1 cycle; sum=0x81, carry_out=0, overflow=1.
- WIDTH=8, sub=0, a=0xFF, b=0x01 -> sum=0x00, carry_out=1, overflow=0. Then sub=1, a=0x80, b=0x01 issued in the DONE cycle -> runs back-to-back; sum=0x7F, carry_out=1, overflow=1.
- WIDTH=8, sub=1, a=0x10, b=0x20 -> sum=0xF0, carry_out=0 (borrow), overflow=0. Start re-asserted with a=0x55 at cycle 3 of RUN is ignored; result unchanged.
- WIDTH=8, start a=0x12, b=0x34; drop rst_n at cycle 4 of RUN -> busy, done, sum, carry_out and overflow all 0 immediately. No done pulse after release; the next start yields a correct 0x46.
- WIDTH=1, all four (a,b) with sub=0 -> (0,0):sum0 c0; (0,1):1,0; (1,0):1,0; (1,1):0,1. Done arrives 2 cycles after start.
- WIDTH=16, 1000 random operands and modes checked against a+b / a-b reference -> sum, carry_out and overflow match every time. done is asserted exactly WIDTH+1 cycles after each accepted start.
